// File: rtl/wb_data_router_if.sv
// Bus bundle for wb_data_router: the CPU-side pipelined Wishbone master and the fanned-out slave ports.
// The master modport is the environment's view, and the slave modport is the router's view.
interface wb_data_router_if #(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
);
  logic                     m_cyc_i;
  logic                     m_stb_i;
  logic                     m_we_i;
  logic [AW-1:0]            m_adr_i;
  logic [DW/8-1:0]          m_sel_i;
  logic [DW-1:0]            m_dat_i;
  logic [DW-1:0]            m_dat_o;
  logic                     m_ack_o;
  logic                     m_err_o;
  logic                     m_stall_o;
  logic [NUM_SLAVES-1:0]    s_cyc_o;
  logic [NUM_SLAVES-1:0]    s_stb_o;
  logic                     s_we_o;
  logic [AW-1:0]            s_adr_o;
  logic [DW/8-1:0]          s_sel_o;
  logic [DW-1:0]            s_dat_o;
  logic [NUM_SLAVES*DW-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]    s_ack_i;
  logic [NUM_SLAVES-1:0]    s_err_i;
  logic [NUM_SLAVES-1:0]    s_stall_i;

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i, s_stall_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i, s_stall_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );
endinterface

// File: rtl/wb_data_router.sv
// Data-side Wishbone router: one pipelined master to NUM_SLAVES slaves plus an internal error slot.
// The optional response watchdog is enabled by defining WB_DATA_ROUTER_TIMEOUT_EN.
module wb_data_router #(
  parameter int unsigned                        NUM_SLAVES      = 3,
  parameter int unsigned                        AW              = 32,
  parameter int unsigned                        DW              = 32,
  parameter int unsigned                        MAX_OUTSTANDING = 4,
  parameter logic [NUM_SLAVES-1:0][AW-1:0]      START_ADDRESS   = '0,
  parameter logic [NUM_SLAVES-1:0][AW-1:0]      MASK            = '0,
  parameter int unsigned                        TIMEOUT_CYCLES  = 1024
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_data_router_if.slave bus
);
  localparam int unsigned   TW      = $clog2(NUM_SLAVES + 1);
  localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] ErrSlot = TW'(NUM_SLAVES);
  localparam logic [CW-1:0] CntMax  = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] r_cnt, w_cnt_d;
  logic [CW-1:0] r_err_pend, w_err_pend_d;
  logic [TW-1:0] r_cur_tgt, w_cur_tgt_d;

  logic [TW-1:0] w_dec_tgt;
  logic          w_tgt_stall, w_cur_ack, w_cur_err;
  logic [DW-1:0] w_cur_dat;
  logic          w_busy, w_block, w_stall, w_accept;
  logic          w_slv_resp, w_err_resp, w_resp, w_timeout;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_dec_tgt = ErrSlot;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_adr_i & MASK[i]) == START_ADDRESS[i]) w_dec_tgt = TW'(i);
    end
  end

  always_comb begin
    w_tgt_stall = 1'b0;
    w_cur_ack   = 1'b0;
    w_cur_err   = 1'b0;
    w_cur_dat   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (w_dec_tgt == TW'(k)) w_tgt_stall = bus.s_stall_i[k];
      if (r_cur_tgt == TW'(k)) begin
        w_cur_ack = bus.s_ack_i[k];
        w_cur_err = bus.s_err_i[k];
        w_cur_dat = bus.s_dat_i[k*DW +: DW];
      end
    end
  end

  assign w_busy     = (r_cnt != '0);
  assign w_block    = (r_cnt == CntMax) | (w_busy & (w_dec_tgt != r_cur_tgt));
  assign w_stall    = bus.m_stb_i & (w_block | w_tgt_stall);
  assign w_accept   = bus.m_cyc_i & bus.m_stb_i & ~w_stall;
  assign w_slv_resp = bus.m_cyc_i & w_busy & (r_cur_tgt != ErrSlot) & (w_cur_ack | w_cur_err);
  assign w_err_resp = bus.m_cyc_i & (r_err_pend != '0);
  assign w_resp     = w_slv_resp | w_err_resp;

`ifdef WB_DATA_ROUTER_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wdog;

  assign w_timeout = bus.m_cyc_i & w_busy & ~w_resp & ~w_accept &
                     (r_wdog == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= '0;
    end else if (!bus.m_cyc_i || !w_busy || w_resp || w_accept || w_timeout) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  // Watchdog compiled out; the router waits on the slave indefinitely.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    w_cnt_d      = r_cnt;
    w_err_pend_d = r_err_pend;
    w_cur_tgt_d  = r_cur_tgt;
    if (!bus.m_cyc_i || w_timeout) begin
      w_cnt_d      = '0;
      w_err_pend_d = '0;
    end else begin
      w_cnt_d      = r_cnt + CW'(w_accept) - CW'(w_resp);
      w_err_pend_d = r_err_pend + CW'(w_accept && (w_dec_tgt == ErrSlot)) - CW'(w_err_resp);
    end
    if (w_accept) w_cur_tgt_d = w_dec_tgt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_err_pend <= '0;
      r_cur_tgt  <= '0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_err_pend <= w_err_pend_d;
      r_cur_tgt  <= w_cur_tgt_d;
    end
  end

  always_comb begin
    bus.m_stall_o = 1'b0;
    bus.m_ack_o   = 1'b0;
    bus.m_err_o   = 1'b0;
    bus.m_dat_o   = '0;
    bus.s_cyc_o   = '0;
    bus.s_stb_o   = '0;
    bus.s_we_o    = 1'b0;
    bus.s_adr_o   = '0;
    bus.s_sel_o   = '0;
    bus.s_dat_o   = '0;
    if (!rst_i) begin
      bus.m_stall_o = w_stall;
      bus.m_ack_o   = w_slv_resp & w_cur_ack;
      bus.m_err_o   = (w_slv_resp & w_cur_err) | w_err_resp | w_timeout;
      bus.m_dat_o   = (w_slv_resp & w_cur_ack) ? w_cur_dat : '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
        bus.s_stb_o[k] = bus.m_cyc_i & bus.m_stb_i & ~w_block & (w_dec_tgt == TW'(k));
        bus.s_cyc_o[k] = bus.m_cyc_i & ~(w_timeout & (r_cur_tgt == TW'(k))) &
                         ((w_busy & (r_cur_tgt == TW'(k))) |
                          (bus.m_stb_i & (w_dec_tgt == TW'(k)) & ~w_block));
      end
      bus.s_we_o  = bus.m_we_i;
      bus.s_adr_o = bus.m_adr_i;
      bus.s_sel_o = bus.m_sel_i;
      bus.s_dat_o = bus.m_dat_i;
    end
  end
endmodule

// File: doc/wb_data_router.md
Name: wb_data_router

Overview:
- Parametrised successor to the data-side Wishbone interconnect. Routes one pipelined Wishbone master (CPU data port) to NUM_SLAVES slaves (e.g. DCCM, D$, main mux) by address/mask decode.
- Adds an internal error responder for unmapped addresses and tracks up to MAX_OUTSTANDING in-flight requests.
- Enforces in-order response routing by stalling when the target changes.
- Sits between the CPU load/store unit and the data-side slaves.

Parameters:
- NUM_SLAVES, 3: number of real slave ports.
- AW, 32: address width.
- DW, 32: data width; SEL width is DW/8.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered requests; must be ≥1.
- START_ADDRESS, {NUM_SLAVES{AW'h0}}: per-slave base address array.
- MASK, {NUM_SLAVES{AW'h0}}: per-slave decode mask array.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable.
- m_adr_i  in  AW  master address.
- m_sel_i  in  DW/8  master byte selects.
- m_dat_i  in  DW  master write data.
- m_dat_o  out  DW  read data to master.
- m_ack_o, m_err_o, m_stall_o  out  1 each  responses to master.
- s_cyc_o, s_stb_o  out  NUM_SLAVES  per-slave cycle and strobe.
- s_we_o  out  1  broadcast write enable.
- s_adr_o  out  AW  broadcast address.
- s_sel_o  out  DW/8  broadcast byte selects.
- s_dat_o  out  DW  broadcast write data.
- s_dat_i  in  NUM_SLAVES*DW  per-slave read data.
- s_ack_i, s_err_i, s_stall_i  in  NUM_SLAVES each  per-slave responses.

Behaviour:
- Decode (combinational on m_adr_i): slave i hits when (m_adr_i & MASK[i]) == START_ADDRESS[i]. Lowest index wins on multiple hits. No hit selects target index NUM_SLAVES, the internal error slot.
- State registers:
  - cnt: outstanding count, 0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1).
  - cur_tgt: current target, 0..NUM_SLAVES.
  - err_pend: pending internal errors.
- Routing gate: `block = (cnt == MAX_OUTSTANDING) | (cnt != 0 & dec_tgt != cur_tgt)`.
- Master stall:
  - `m_stall_o = block | (dec_tgt < NUM_SLAVES ? s_stall_i[dec_tgt] : 0)`.
  - m_stall_o is 0 when m_stb_i is low.
- Forwarding: s_stb_o[dec_tgt] = m_stb_i & m_cyc_i & ~block; all other strobes are 0.
- s_cyc_o[k] = m_cyc_i & ((cnt != 0 & cur_tgt == k) | (m_stb_i & dec_tgt == k & ~block)).
- Acceptance: occurs when m_cyc_i & m_stb_i & ~m_stall_o. On accept, cur_tgt <= dec_tgt.
- Response from a real slave: in the cycle s_ack_i/s_err_i[cur_tgt] is high with cnt != 0, m_ack_o/m_err_o mirror it and m_dat_o = s_dat_i[cur_tgt]. There is zero added latency.
- Response from the error slot: each accepted unmapped request increments err_pend. While err_pend > 0, m_err_o = 1 for one cycle per pending error, starting the cycle after acceptance.
- cnt update:
  - +1 on accept, −1 on response.
  - Both in the same cycle: cnt is unchanged.
  - Responses from non-current slaves, or with cnt == 0, are ignored and never forwarded.
- m_dat_o is 0 when no ack is forwarded.
- Cycle abort: if m_cyc_i falls while cnt != 0, then next cycle cnt = 0, err_pend = 0 and all s_cyc_o = 0. Late slave responses are dropped.
- Reset (rst_i high, any time, mid-burst included):
  - All outputs 0.
  - cnt = 0, err_pend = 0, cur_tgt = 0.
- s_we_o, s_adr_o, s_sel_o and s_dat_o pass through combinationally from the master.

Optional Feature:
- Macro: WB_DATA_ROUTER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles with cnt != 0 and no response; it resets on any response or accept.
  - On reaching TIMEOUT_CYCLES, m_err_o = 1 for one cycle, cnt is cleared, and s_cyc_o of cur_tgt is forced to 0 for that cycle.
- Not defined: no watchdog; the router waits indefinitely for a response.

Test Plan:
1. Single read to slave 1 (base 0x1000_0000, mask 0xF000_0000), slave acks 2 cycles later with 0xDEADBEEF → m_ack_o high one cycle, m_dat_o = 0xDEADBEEF, cnt returns to 0.
2. 4 back-to-back writes to slave 0, slave delays all acks → 5th strobe stalled while cnt = 4. It is accepted the cycle after the first ack.
3. Read to slave 0 followed immediately by a read to slave 2, slave 0 acks after 3 cycles → second request stalled until cnt = 0, then forwarded to slave 2. Responses arrive in order.
4. Two pipelined accesses to unmapped address 0x7000_0000 → m_err_o high on the two cycles following each accept. No s_stb_o asserted.
5. m_cyc_i dropped with 2 outstanding, then a slave ack arrives → ack not forwarded, cnt = 0. Repeat with rst_i asserted mid-burst → all outputs 0 immediately.
6. With WB_DATA_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never acks → m_err_o pulses exactly 16 cycles after the last accept, and cnt = 0.
